// File: rtl/hid_serial_master_if.sv
// Byte-stream and hid bus signal bundle for the serial bus master.
// master modport: seen from the bridge; slave modport: seen from the UART FIFOs and bus fabric.
// Handshakes: rx/tx use valid&ready; hid bus is a single-beat strobe with fixed read latency.
interface hid_serial_master_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        hid_en;
  logic [7:0]  hid_we;
  logic [17:0] hid_addr;
  logic [63:0] hid_wrdata;
  logic [63:0] hid_rddata;

  modport master (
    input  rx_valid, rx_data, tx_ready, hid_rddata,
    output rx_ready, tx_valid, tx_data, hid_en, hid_we, hid_addr, hid_wrdata
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, hid_rddata,
    input  rx_ready, tx_valid, tx_data, hid_en, hid_we, hid_addr, hid_wrdata
  );
endinterface

// File: rtl/hid_serial_master.sv
// UART command frames ('R'/'W') -> single-beat hid bus accesses -> read data / ACK / NAK bytes.
// Latency: hid_en one cycle after the last frame byte; response RD_LATENCY+1 (read) or 1 (write) later.
// Backpressure: rx held off outside frame parsing; tx bytes held stable until tx_ready.
module hid_serial_master #(
  parameter int         RD_LATENCY     = 1,
  parameter int         TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic                 msoc_clk,
  input  logic                 rstn,
  hid_serial_master_if.master  bus,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ADDR, MASK, DATA, BUS, WAIT, RESP, NAK} state_t;

  state_t        state, state_nxt;
  logic          is_wr;
  // Shared counter: address bytes, data bytes, read latency, then remaining response bytes.
  logic [2:0]    cnt;
  logic [17:0]   addr;
  logic [7:0]    mask;
  logic [63:0]   wrdata;
  logic [63:0]   resp;
  logic [TW-1:0] tmo;
  logic          in_frame, rx_fire, tx_fire, tmo_hit;

  // Handshake decode and outputs, all derived from registered state so reset clears them at once.
  always_comb begin
    in_frame       = (state == ADDR) || (state == MASK) || (state == DATA);
    bus.rx_ready   = (state == IDLE) || in_frame;
    rx_fire        = bus.rx_ready && bus.rx_valid;
    bus.tx_valid   = (state == RESP) || (state == NAK);
    tx_fire        = bus.tx_valid && bus.tx_ready;
    bus.tx_data    = (state == NAK) ? NAK_BYTE : resp[63:56];
    bus.hid_en     = (state == BUS);
    bus.hid_we     = ((state == BUS) && is_wr) ? mask : 8'h00;
    bus.hid_addr   = addr;
    bus.hid_wrdata = wrdata;
    // A byte landing on the final timeout cycle still wins over the abort.
    tmo_hit        = in_frame && !rx_fire && (tmo == TW'(TIMEOUT_CYCLES - 1));
    frame_err      = tmo_hit;
    busy           = (state != IDLE);
  end

  // Next-state selection for the frame parser / bus / response sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_fire) state_nxt = (bus.rx_data == 8'h52 || bus.rx_data == 8'h57) ? ADDR : NAK;
      ADDR: if (tmo_hit) state_nxt = IDLE;
            else if (rx_fire && cnt == 3'd2) state_nxt = is_wr ? MASK : BUS;
      MASK: if (tmo_hit) state_nxt = IDLE;
            else if (rx_fire) state_nxt = (bus.rx_data == 8'h00) ? NAK : DATA;
      DATA: if (tmo_hit) state_nxt = IDLE;
            else if (rx_fire && cnt == 3'd7) state_nxt = BUS;
      BUS:  state_nxt = is_wr ? RESP : WAIT;
      WAIT: if (cnt == 3'(RD_LATENCY)) state_nxt = RESP;
      RESP: if (tx_fire && cnt == 3'd0) state_nxt = IDLE;
      NAK:  if (tx_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, frame capture, read-latency counting and response shifting.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      is_wr  <= 1'b0;
      cnt    <= 3'd0;
      addr   <= 18'h0;
      mask   <= 8'h00;
      wrdata <= 64'h0;
      resp   <= 64'h0;
      tmo    <= '0;
    end else begin
      state <= state_nxt;
      if (!in_frame || rx_fire || tmo_hit) tmo <= '0;
      else                                 tmo <= tmo + 1'b1;
      case (state)
        IDLE: if (rx_fire) begin
          is_wr <= (bus.rx_data == 8'h57);
          cnt   <= 3'd0;
        end
        ADDR: if (rx_fire) begin
          addr <= {addr[9:0], bus.rx_data};
          cnt  <= cnt + 3'd1;
        end
        MASK: if (rx_fire) begin
          mask <= bus.rx_data;
          cnt  <= 3'd0;
        end
        DATA: if (rx_fire) begin
          wrdata <= {wrdata[55:0], bus.rx_data};
          cnt    <= cnt + 3'd1;
        end
        BUS: begin
          if (is_wr) begin
            resp <= {ACK_BYTE, 56'h0};
            cnt  <= 3'd0;
          end else begin
            cnt  <= 3'd1;
          end
        end
        WAIT: begin
          if (cnt == 3'(RD_LATENCY)) begin
            resp <= bus.hid_rddata;
            cnt  <= 3'd7;
          end else begin
            cnt  <= cnt + 3'd1;
          end
        end
        RESP: if (tx_fire) begin
          resp <= {resp[55:0], 8'h00};
          cnt  <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hid_serial_master.sv
// Directed bench for hid_serial_master with a frame-level expectation model.
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
// Expected bus cycles and response bytes are queued per frame and consumed by one compare process.
module tb_hid_serial_master;

  typedef struct {
    logic [17:0] addr;
    logic [7:0]  we;
    logic [63:0] data;
  } bus_t;

  logic msoc_clk = 1'b0;
  logic rstn;
  logic busy, frame_err;
  hid_serial_master_if bus_if ();

  hid_serial_master #(.RD_LATENCY(1), .TIMEOUT_CYCLES(100), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .msoc_clk  (msoc_clk),
    .rstn      (rstn),
    .bus       (bus_if.master),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 msoc_clk = ~msoc_clk;

  int cyc = 0;
  always @(posedge msoc_clk) cyc <= cyc + 1;

  // Slave: data for the most recent strobe appears one cycle later, garbage otherwise.
  logic [63:0] slave_mem;
  always @(posedge msoc_clk) bus_if.hid_rddata <= bus_if.hid_en ? slave_mem : 64'h5A5A_A5A5_5A5A_A5A5;

  int n_cmp = 0;
  int n_bad = 0;
  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int acc_cyc, en_cyc, first_tx_cyc, tx_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: what one complete frame must produce on the bus and on tx.
  task automatic model_frame(input logic [7:0] f[$]);
    bus_t e;
    logic [23:0] a;
    if (f[0] == 8'h52) begin
      a = {f[1], f[2], f[3]};
      e.addr = a[17:0]; e.we = 8'h00; e.data = 64'h0;
      exp_bus.push_back(e);
      for (int i = 0; i < 8; i++) exp_tx.push_back(slave_mem[63-8*i -: 8]);
    end else if (f[0] == 8'h57 && f[4] != 8'h00) begin
      a = {f[1], f[2], f[3]};
      e.addr = a[17:0]; e.we = f[4]; e.data = 64'h0;
      for (int i = 0; i < 8; i++) e.data = {e.data[55:0], f[5+i]};
      exp_bus.push_back(e);
      exp_tx.push_back(8'h06);
    end else begin
      exp_tx.push_back(8'h15);
    end
  endtask

  // Compare process: every bus strobe and every tx transfer against the model queues.
  logic       prev_stall, prev_valid;
  logic [7:0] prev_data;
  bus_t       e_got;
  always @(negedge msoc_clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus_if.hid_en) begin
        en_cyc = cyc;
        if (exp_bus.size() == 0) chk("unexpected_hid_en", 1, 0);
        else begin
          e_got = exp_bus.pop_front();
          chk("hid_addr", bus_if.hid_addr, e_got.addr);
          chk("hid_we", bus_if.hid_we, e_got.we);
          if (e_got.we != 8'h00) chk("hid_wrdata", bus_if.hid_wrdata, e_got.data);
        end
      end else begin
        chk("hid_we_idle", bus_if.hid_we, 0);
      end
      if (bus_if.tx_valid) chk("rx_ready_while_resp", bus_if.rx_ready, 0);
      if (prev_stall) begin
        chk("tx_valid_held", bus_if.tx_valid, 1);
        chk("tx_data_held", bus_if.tx_data, prev_data);
      end
      if (bus_if.tx_valid && !prev_valid) first_tx_cyc = cyc;
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        if (exp_tx.size() == 0) chk("unexpected_tx", 1, 0);
        else chk("tx_data", bus_if.tx_data, exp_tx.pop_front());
        tx_seen++;
      end
      prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
      prev_valid = bus_if.tx_valid;
      prev_data  = bus_if.tx_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    @(negedge msoc_clk);
    while (!bus_if.rx_ready && n < 200) begin
      @(negedge msoc_clk);
      n++;
    end
    if (!bus_if.rx_ready) chk("rx_accept_timeout", 1, 0);
    acc_cyc = cyc;
    @(posedge msoc_clk); #1;
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  // Wait for the frame's effects to drain; optional tx_ready toggling.
  task automatic wait_done(input bit toggle);
    int n = 0;
    forever begin
      @(negedge msoc_clk);
      if (!busy && exp_tx.size() == 0 && exp_bus.size() == 0) break;
      if (n++ > 500) begin
        chk("wait_done_timeout", 1, 0);
        exp_tx.delete();
        exp_bus.delete();
        break;
      end
      @(posedge msoc_clk); #1;
      if (toggle) bus_if.tx_ready = ~bus_if.tx_ready;
    end
    bus_if.rx_valid = 1'b0;
    @(posedge msoc_clk); #1;
    bus_if.tx_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (%0d compared)", n_cmp);
    $fatal(1, "watchdog");
  end

  logic [7:0] fr[$];
  int fe_cyc;

  initial begin
    rstn = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.tx_ready = 1'b1;
    slave_mem = 64'h0;
    tx_seen = 0;
    repeat (3) @(posedge msoc_clk);
    #1;
    chk("rst_hid_en", bus_if.hid_en, 0);
    chk("rst_hid_we", bus_if.hid_we, 0);
    chk("rst_hid_addr", bus_if.hid_addr, 0);
    chk("rst_hid_wrdata", bus_if.hid_wrdata, 0);
    chk("rst_tx_valid", bus_if.tx_valid, 0);
    chk("rst_tx_data", bus_if.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    rstn = 1'b1;
    @(posedge msoc_clk); #1;

    // Write frame -> one strobe, ACK.
    fr = '{8'h57, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    model_frame(fr);
    chk("model_wr_addr", exp_bus[0].addr, 18'h00010);
    chk("model_wr_data", exp_bus[0].data, 64'h0123456789ABCDEF);
    send_frame(fr);
    wait_done(0);
    chk("wr_hid_en_latency", 64'(en_cyc - acc_cyc), 1);
    chk("wr_ack_latency", 64'(first_tx_cyc - acc_cyc), 2);

    // Read frame -> 8 bytes MSB first.
    slave_mem = 64'hDEADBEEF00C0FFEE;
    fr = '{8'h52, 8'h01, 8'h00, 8'h08};
    model_frame(fr);
    chk("model_rd_addr", exp_bus[0].addr, 18'h10008);
    chk("model_rd_first", exp_tx[0], 8'hDE);
    chk("model_rd_last", exp_tx[7], 8'hEE);
    send_frame(fr);
    chk("busy_after_frame", busy, 1);
    wait_done(0);
    chk("rd_hid_en_latency", 64'(en_cyc - acc_cyc), 1);
    chk("rd_first_tx_latency", 64'(first_tx_cyc - acc_cyc), 3);

    // Illegal command byte and zero write mask -> NAK, no strobe.
    fr = '{8'h41};
    model_frame(fr);
    send_frame(fr);
    wait_done(0);
    fr = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00};
    model_frame(fr);
    chk("model_zero_mask_nak", exp_tx[0], 8'h15);
    send_frame(fr);
    wait_done(0);
    chk("zero_mask_idle_busy", busy, 0);
    chk("zero_mask_idle_rx_ready", bus_if.rx_ready, 1);

    // Read with tx_ready toggling and a pending rx byte held off.
    slave_mem = 64'h1122334455667788;
    fr = '{8'h52, 8'h00, 8'h7F, 8'hF0};
    model_frame(fr);
    send_frame(fr);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 8'h52;
    wait_done(1);

    // Inter-byte timeout after two bytes.
    send_byte(8'h52);
    send_byte(8'h00);
    fe_cyc = -1000;
    for (int i = 0; i < 300; i++) begin
      @(negedge msoc_clk);
      if (frame_err) begin
        fe_cyc = cyc;
        break;
      end
    end
    chk("timeout_cycles", 64'(fe_cyc - acc_cyc), 100);
    @(negedge msoc_clk);
    chk("frame_err_one_cycle", frame_err, 0);
    chk("timeout_busy_low", busy, 0);
    @(posedge msoc_clk); #1;
    slave_mem = 64'hA5A5_0102_0304_5A5A;
    fr = '{8'h52, 8'h02, 8'h34, 8'h56};
    model_frame(fr);
    send_frame(fr);
    wait_done(0);

    // Reset while the fourth read byte is presented.
    slave_mem = 64'hCAFEF00D12345678;
    fr = '{8'h52, 8'h00, 8'h00, 8'h20};
    model_frame(fr);
    send_frame(fr);
    tx_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge msoc_clk); #1;
      if (tx_seen >= 3) break;
    end
    chk("rst_mid_tx_seen", tx_seen, 3);
    rstn = 1'b0;
    #1;
    chk("rst_mid_tx_valid", bus_if.tx_valid, 0);
    chk("rst_mid_hid_en", bus_if.hid_en, 0);
    chk("rst_mid_busy", busy, 0);
    exp_tx.delete();
    exp_bus.delete();
    @(posedge msoc_clk); #1;
    rstn = 1'b1;
    @(posedge msoc_clk); #1;
    fr = '{8'h57, 8'h03, 8'hFF, 8'hFE, 8'h0F, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    model_frame(fr);
    chk("model_post_rst_addr", exp_bus[0].addr, 18'h3FFFE);
    send_frame(fr);
    wait_done(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hid_serial_master.md
Name: hid_serial_master

Overview:
- Byte-stream-to-hid-bus bridge; this is the initiator end of the hid peripheral bus.
- Parses command frames arriving from a UART receive FIFO.
- Issues single-beat hid bus reads and writes (hid_en/hid_we/hid_addr/hid_wrdata).
- Returns read data or status bytes to a UART transmit FIFO.
- Sits between the debug UART byte interface and the peripheral/RAM slave fabric for board bring-up without a running core.

Parameters:
RD_LATENCY, 1, cycles from the hid_en pulse to valid hid_rddata (1..4)
TIMEOUT_CYCLES, 50000000, max msoc_clk cycles between bytes inside a frame before abort
ACK_BYTE, 8'h06, response byte for a completed write
NAK_BYTE, 8'h15, response byte for an illegal command or a zero write mask

Ports:
msoc_clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rx_valid  in  1  receive byte available
rx_data  in  8  receive byte
rx_ready  out  1  pop receive byte (transfer when rx_valid&rx_ready)
tx_valid  out  1  response byte valid
tx_data  out  8  response byte
tx_ready  in  1  transmit sink accepts (transfer when tx_valid&tx_ready)
hid_en  out  1  bus cycle strobe, one cycle per access
hid_we  out  8  byte write enables; 0 = read
hid_addr  out  18  bus address, passed verbatim ([17:15] selects slave)
hid_wrdata  out  64  write data
hid_rddata  in  64  read data, valid RD_LATENCY cycles after hid_en
busy  out  1  high whenever state != IDLE
frame_err  out  1  one-cycle pulse on inter-byte timeout abort

Behaviour:
- Reset is asynchronous, active-low, on rstn; clock is msoc_clk.
- Reset values:
  - all outputs 0, state IDLE, counters 0;
  - hid_addr/hid_wrdata/hid_we = 0.
- Frame formats:
  - Read: 'R' (8'h52), A2, A1, A0.
  - Write: 'W' (8'h57), A2, A1, A0, M, D7..D0.
  - Address = {A2,A1,A0}[17:0], big-endian; A2[7:2] ignored.
  - M = write mask; D7 = hid_wrdata[63:56] first.
- States: IDLE, ADDR, MASK, DATA, BUS, WAIT, RESP, NAK.
  - IDLE: rx_ready=1. 'R'/'W' -> ADDR (cmd latched); any other byte -> NAK.
  - ADDR: accept 3 bytes (2-bit counter), shift into address. Then R -> BUS, W -> MASK.
  - MASK: accept 1 byte. 8'h00 -> NAK (no bus cycle, remaining 8 data bytes are not consumed by this frame); else -> DATA.
  - DATA: accept 8 bytes (3-bit counter) into hid_wrdata, MSB first; -> BUS.
  - BUS: hid_en=1 for exactly one cycle; hid_we = M for write, 8'h00 for read.
    - write -> RESP with tx_data=ACK_BYTE;
    - read -> WAIT.
  - WAIT: count RD_LATENCY cycles from the hid_en cycle. On the last one, capture hid_rddata into the response shift register; -> RESP.
  - RESP: present bytes; each advances on tx_valid&tx_ready.
    - Read: 8 bytes, [63:56] first.
    - Write: 1 byte.
    - After the last transfer -> IDLE.
  - NAK: tx_data=NAK_BYTE until accepted; -> IDLE.
- rx_ready is 1 only in IDLE/ADDR/MASK/DATA. Bytes arriving during BUS/WAIT/RESP/NAK are held off in the source FIFO, never dropped.
- Bus signal rules:
  - hid_addr is stable from the BUS cycle through the capture cycle.
  - hid_wrdata is stable during BUS.
  - hid_en and hid_we are 0 in every other state.
- Latency: last frame byte accepted in cycle N.
  - hid_en in N+1.
  - Read: capture in N+1+RD_LATENCY; first tx_valid in N+2+RD_LATENCY.
  - Write: tx_valid (ACK) in N+2.
- tx_valid/tx_data are held unchanged while tx_ready=0. With tx_ready held 1, one byte transfers per cycle (8-byte read response in 8 consecutive cycles).
- Timeout:
  - Counter clears on every accepted byte and in IDLE; it increments in ADDR/MASK/DATA while no byte is accepted.
  - Reaching TIMEOUT_CYCLES: frame_err pulses 1 cycle, go to IDLE, no bus cycle, no response.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - No timeout in RESP (waits on tx_ready indefinitely).
- rstn asserted mid-frame or mid-response: immediate return to IDLE, with hid_en=0 and tx_valid=0 asynchronously. The partial frame is discarded.

Test Plan:
- Write: bytes 57 00 00 10 FF 01 23 45 67 89 AB CD EF -> single hid_en cycle with hid_addr=18'h00010, hid_we=8'hFF, hid_wrdata=64'h0123456789ABCDEF; then one tx byte 06.
- Read, RD_LATENCY=1: bytes 52 01 00 08, slave returns 64'hDEADBEEF00C0FFEE one cycle after hid_en -> hid_we=0 and hid_addr=18'h10008 during the cycle; tx bytes DE AD BE EF 00 C0 FF EE in order; first tx_valid exactly 3 cycles after the last rx byte.
- Illegal/zero-mask: byte 41 -> tx 15, no hid_en. Frame 57 00 00 00 00 -> tx 15, no hid_en, back in IDLE.
- Backpressure: read with tx_ready toggling 1/0 every cycle -> 8 bytes, correct order, tx_data stable while stalled; rx_ready=0 throughout RESP even with rx_valid=1.
- Timeout (TIMEOUT_CYCLES=100): send 52 00 then idle -> frame_err pulse exactly 100 cycles after byte 2, busy drops, no hid_en; a following valid read completes normally.
- Reset mid-read: assert rstn=0 during RESP byte 3 -> tx_valid=0, hid_en=0, busy=0 immediately; after release a fresh write frame yields ACK 06.
